// File: rtl/ssc_uart_pkg.sv
// Shared types and constants for the SuperSerial UART receive/transmit paths.
package ssc_uart_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int PH_W       = $clog2(OVERSAMPLE);

   // Oversample ticks within a bit used for the 2-of-3 majority vote
   localparam logic [PH_W-1:0] SMP_A = PH_W'(7);
   localparam logic [PH_W-1:0] SMP_B = PH_W'(8);
   localparam logic [PH_W-1:0] SMP_C = PH_W'(9);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP1,
      STOP2,
      BRKWAIT
   } rx_state_e;

   typedef struct packed {
      logic       brk;
      logic       ferr;
      logic       perr;
      logic [7:0] data;
   } rx_entry_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/ssc_uart_fifo.sv
// First-word-fall-through FIFO of rx_entry_t with occupancy and drop indication.
module ssc_uart_fifo
   import ssc_uart_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk_logic,
   input  logic                     reset,
   input  logic                     push,
   input  rx_entry_t                din,
   input  logic                     pop,
   output rx_entry_t                dout,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   rx_entry_t         mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              full;
   logic              do_push;
   logic              do_pop;

   assign valid   = (count != '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & valid;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept
   assign do_push = push & (~full | do_pop);
   assign ovf     = push & full & ~do_pop;
   assign dout    = valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk_logic) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk_logic) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ssc_uart_rx.sv
// SuperSerial UART receiver: 16x oversampled deframer feeding a small FWFT FIFO.
module ssc_uart_rx
   import ssc_uart_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          clk_logic,
   input  logic                          reset,
   input  logic                          rx_i,
   input  logic [15:0]                   baud_div_i,
   input  logic [1:0]                    data_bits_i,
   input  logic                          parity_en_i,
   input  logic                          parity_odd_i,
   input  logic                          stop2_i,
   output logic [7:0]                    data_o,
   output logic                          parity_err_o,
   output logic                          framing_err_o,
   output logic                          break_o,
   output logic                          valid_o,
   input  logic                          ready_i,
   output logic                          overrun_o,
   input  logic                          clear_err_i,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
   output logic                          busy_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxs;
   logic                   armed_q;
   logic [15:0]            tick_cnt_q;
   logic                   tick;
   logic [PH_W-1:0]        phase_q;
   logic [2:0]             bit_idx_q;
   logic [7:0]             data_q;
   logic                   perr_q;
   logic                   ferr_q;
   logic                   pbit_q;
   logic                   s_a_q;
   logic                   s_b_q;
   logic                   maj;
   logic                   at_mid;
   logic                   last_bit;
   logic                   brk_now;
   rx_state_e              state_q;
   rx_state_e              state_d;
   logic                   push;
   rx_entry_t              entry;
   rx_entry_t              head;
   logic                   ovf;

   // Reset to 0 so a line already low at reset release cannot arm the receiver
   always_ff @(posedge clk_logic) begin
      if (reset) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
   end
   assign rxs = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk_logic) begin
      if (reset)    armed_q <= 1'b0;
      else if (rxs) armed_q <= 1'b1;
   end

   always_ff @(posedge clk_logic) begin
      if (reset || tick_cnt_q == '0) tick_cnt_q <= baud_div_i;
      else                           tick_cnt_q <= tick_cnt_q - 1'b1;
   end
   assign tick = (tick_cnt_q == '0);

   assign maj      = maj3(s_a_q, s_b_q, rxs);
   assign at_mid   = tick && (phase_q == SMP_C);
   assign last_bit = (bit_idx_q == 3'(data_bits_i) + 3'd4);
   assign brk_now  = (state_q == STOP1) && !maj && (data_q == '0) &&
                     (!parity_en_i || !pbit_q);

   always_ff @(posedge clk_logic) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (armed_q && !rxs) state_d = START;
         START:   if (at_mid) state_d = maj ? IDLE : DATA;
         DATA:    if (at_mid && last_bit) state_d = parity_en_i ? PARITY : STOP1;
         PARITY:  if (at_mid) state_d = STOP1;
         STOP1:   if (at_mid) state_d = brk_now ? BRKWAIT : (stop2_i ? STOP2 : IDLE);
         STOP2:   if (at_mid) state_d = IDLE;
         BRKWAIT: if (rxs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Push at the mid-stop tick so the next start edge is caught without delay
   always_comb begin
      busy_o     = (state_q != IDLE);
      push       = 1'b0;
      entry.brk  = brk_now;
      entry.ferr = ferr_q | ~maj;
      entry.perr = perr_q;
      entry.data = data_q;
      if (at_mid) begin
         if (state_q == STOP1 && (brk_now || !stop2_i)) push = 1'b1;
         if (state_q == STOP2)                          push = 1'b1;
      end
   end

   always_ff @(posedge clk_logic) begin
      if (reset) begin
         phase_q   <= '0;
         bit_idx_q <= '0;
         data_q    <= '0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         pbit_q    <= 1'b0;
         s_a_q     <= 1'b0;
         s_b_q     <= 1'b0;
      end else if (state_q == IDLE && state_d == START) begin
         phase_q   <= '0;
         bit_idx_q <= '0;
         data_q    <= '0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         pbit_q    <= 1'b0;
      end else if (tick && state_q != IDLE) begin
         phase_q <= phase_q + 1'b1;
         if (phase_q == SMP_A) s_a_q <= rxs;
         if (phase_q == SMP_B) s_b_q <= rxs;
         if (phase_q == SMP_C) begin
            case (state_q)
               DATA: begin
                  data_q[bit_idx_q] <= maj;
                  bit_idx_q         <= bit_idx_q + 3'd1;
               end
               PARITY: begin
                  pbit_q <= maj;
                  perr_q <= maj ^ (^data_q) ^ parity_odd_i;
               end
               STOP1:   ferr_q <= ~maj;
               default: ;
            endcase
         end
      end
   end

   ssc_uart_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_logic (clk_logic),
      .reset     (reset),
      .push      (push),
      .din       (entry),
      .pop       (ready_i),
      .dout      (head),
      .valid     (valid_o),
      .count     (fifo_count_o),
      .ovf       (ovf)
   );

   // Set wins over clear when both land in the same cycle
   always_ff @(posedge clk_logic) begin
      if (reset)            overrun_o <= 1'b0;
      else if (ovf)         overrun_o <= 1'b1;
      else if (clear_err_i) overrun_o <= 1'b0;
   end

   assign data_o        = head.data;
   assign parity_err_o  = head.perr;
   assign framing_err_o = head.ferr;
   assign break_o       = head.brk;

endmodule

// File: tb/tb_ssc_uart_rx.sv
// Bench for ssc_uart_rx: serial frame driver, expected-entry queue, table plus corner sequences.
module tb_ssc_uart_rx;

   logic        clk_logic = 1'b0;
   logic        reset = 1'b1;
   logic        rx_i = 1'b1;
   logic [15:0] baud_div_i = 16'd3;
   logic [1:0]  data_bits_i = 2'd3;
   logic        parity_en_i = 1'b0;
   logic        parity_odd_i = 1'b0;
   logic        stop2_i = 1'b0;
   logic [7:0]  data_o;
   logic        parity_err_o;
   logic        framing_err_o;
   logic        break_o;
   logic        valid_o;
   logic        ready_i = 1'b0;
   logic        overrun_o;
   logic        clear_err_i = 1'b0;
   logic [2:0]  fifo_count_o;
   logic        busy_o;

   ssc_uart_rx #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
      .clk_logic     (clk_logic),
      .reset         (reset),
      .rx_i          (rx_i),
      .baud_div_i    (baud_div_i),
      .data_bits_i   (data_bits_i),
      .parity_en_i   (parity_en_i),
      .parity_odd_i  (parity_odd_i),
      .stop2_i       (stop2_i),
      .data_o        (data_o),
      .parity_err_o  (parity_err_o),
      .framing_err_o (framing_err_o),
      .break_o       (break_o),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .overrun_o     (overrun_o),
      .clear_err_i   (clear_err_i),
      .fifo_count_o  (fifo_count_o),
      .busy_o        (busy_o)
   );

   always #5 clk_logic = ~clk_logic;

   typedef struct {
      logic [7:0]  d;
      int          nb;
      bit          pen;
      bit          odd;
      bit          s2;
      bit          badp;
      bit          stl;
      int          bclk;
      logic [10:0] exp;   // {brk, ferr, perr, data}
   } vec_t;

   localparam int NV = 10;
   vec_t        tv [NV];
   logic [10:0] sb [$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          chg_cyc = 0;
   int          start_cyc = 0;
   logic [2:0]  prev_cnt = 3'd0;

   always @(posedge clk_logic) cyc <= cyc + 1;

   // Remember the cycle of the last occupancy change to locate pushes
   always @(negedge clk_logic) begin
      if (fifo_count_o !== prev_cnt) chg_cyc = cyc;
      prev_cnt = fifo_count_o;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk_logic);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, got, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input int nb, input bit pen, input bit odd,
                             input bit s2, input bit badp, input bit stl, input int bclk);
      logic [7:0] m;
      m            = 8'hFF >> (8 - nb);
      data_bits_i  = 2'(nb - 5);
      parity_en_i  = pen;
      parity_odd_i = odd;
      stop2_i      = s2;
      start_cyc    = cyc;
      rx_i = 1'b0;
      idle(bclk);
      for (int i = 0; i < nb; i++) begin
         rx_i = d[i];
         idle(bclk);
      end
      if (pen) begin
         rx_i = (^(d & m)) ^ odd ^ badp;
         idle(bclk);
      end
      rx_i = ~stl;
      idle(bclk);
      if (s2) begin
         rx_i = 1'b1;
         idle(bclk);
      end
      rx_i = 1'b1;
      idle(2 * bclk);
   endtask

   task automatic pop_check(input string name);
      int n;
      logic [10:0] e;
      logic [10:0] g;
      n = 0;
      while (!valid_o && n < 3000) begin
         idle(1);
         n++;
      end
      g = {break_o, framing_err_o, parity_err_o, data_o};
      if (!valid_o) begin
         total++;
         bad++;
         $display("FAIL %s: timeout, valid_o stayed 0", name);
         return;
      end
      if (sb.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: unexpected entry %0h, none queued", name, g);
      end else begin
         e = sb.pop_front();
         chk(name, 32'(g), 32'(e));
      end
      ready_i = 1'b1;
      idle(1);
      ready_i = 1'b0;
   endtask

   initial begin
      int lat;
      int delta;
      int s4;
      int s5;
      logic [10:0] e;

      tv[0] = '{8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64, 11'h0A5};
      tv[1] = '{8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64, 11'h141};
      tv[2] = '{8'hC1, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64, 11'h041};
      tv[3] = '{8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64, 11'h255};
      tv[4] = '{8'h1F, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64, 11'h01F};
      tv[5] = '{8'h2A, 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 66, 11'h02A};
      tv[6] = '{8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 62, 11'h000};
      tv[7] = '{8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 66, 11'h0FF};
      tv[8] = '{8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 62, 11'h0FF};
      tv[9] = '{8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 66, 11'h000};

      idle(4);
      chk("reset_outs", 32'({data_o, parity_err_o, framing_err_o, break_o, valid_o,
                             overrun_o, fifo_count_o, busy_o}), 32'd0);
      reset = 1'b0;
      idle(128);
      chk("idle_busy", 32'(busy_o), 32'd0);

      for (int i = 0; i < NV; i++) begin
         send_frame(tv[i].d, tv[i].nb, tv[i].pen, tv[i].odd, tv[i].s2, tv[i].badp,
                    tv[i].stl, tv[i].bclk);
         sb.push_back(tv[i].exp);
         if (i == 0) begin
            // start edge + 2 sync + 1 detect + up to 4 tick phase + 153 ticks of 4
            lat = chg_cyc - start_cyc;
            total++;
            if (lat < 616 || lat > 619) begin
               bad++;
               $display("FAIL valid_latency: got %0d cycles want 616..619", lat);
            end
         end
         pop_check("table_entry");
         chk("table_drain", 32'(fifo_count_o), 32'd0);
      end

      // Break: 12 bit-times low
      data_bits_i = 2'd3; parity_en_i = 1'b0; stop2_i = 1'b0;
      rx_i = 1'b0;
      idle(12 * 64);
      rx_i = 1'b1;
      idle(2 * 64);
      sb.push_back(11'h600);
      chk("brk_count", 32'(fifo_count_o), 32'd1);
      chk("brk_busy", 32'(busy_o), 32'd0);
      pop_check("break_entry");

      // Quarter-bit glitch is a false start
      rx_i = 1'b0;
      idle(16);
      rx_i = 1'b1;
      idle(3 * 64);
      chk("glitch_count", 32'(fifo_count_o), 32'd0);
      chk("glitch_busy", 32'(busy_o), 32'd0);

      // Overrun with ready held low
      for (int k = 1; k <= 5; k++) begin
         send_frame(8'(k), 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64);
         if (k <= 4) sb.push_back(11'(k));
      end
      chk("ovr_count", 32'(fifo_count_o), 32'd4);
      chk("ovr_flag", 32'(overrun_o), 32'd1);
      for (int k = 0; k < 4; k++) pop_check("ovr_entry");
      chk("ovr_sticky", 32'(overrun_o), 32'd1);
      clear_err_i = 1'b1;
      idle(1);
      clear_err_i = 1'b0;
      chk("ovr_clear", 32'(overrun_o), 32'd0);

      // Push and pop in the same cycle while full
      for (int k = 8'h11; k <= 8'h13; k++) begin
         send_frame(8'(k), 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64);
         sb.push_back(11'(k));
      end
      send_frame(8'h14, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64);
      sb.push_back(11'h014);
      s4 = start_cyc;
      delta = chg_cyc - start_cyc;
      while (((cyc - s4) % 4) != 0) idle(1);
      s5 = cyc;
      fork
         send_frame(8'h15, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64);
         begin
            while (cyc < s5 + delta - 1) idle(1);
            e = sb.pop_front();
            chk("full_head", 32'({break_o, framing_err_o, parity_err_o, data_o}), 32'(e));
            ready_i = 1'b1;
            idle(1);
            ready_i = 1'b0;
            chk("full_pp_count", 32'(fifo_count_o), 32'd4);
            chk("full_pp_ovr", 32'(overrun_o), 32'd0);
         end
      join
      sb.push_back(11'h015);
      for (int k = 0; k < 4; k++) pop_check("full_entry");

      // Line held low through reset release
      rx_i = 1'b0;
      reset = 1'b1;
      idle(3);
      reset = 1'b0;
      idle(3 * 64);
      chk("lowrst_busy", 32'(busy_o), 32'd0);
      chk("lowrst_count", 32'(fifo_count_o), 32'd0);
      rx_i = 1'b1;
      idle(64);
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64);
      sb.push_back(11'h03C);
      pop_check("lowrst_entry");

      // Reset mid-frame flushes the FIFO and abandons the frame
      send_frame(8'h77, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64);
      chk("mid_pre_count", 32'(fifo_count_o), 32'd1);
      rx_i = 1'b0; idle(64);
      rx_i = 1'b1; idle(64);
      rx_i = 1'b0; idle(32);
      chk("mid_busy", 32'(busy_o), 32'd1);
      rx_i = 1'b1;
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      idle(1);
      chk("mid_count", 32'(fifo_count_o), 32'd0);
      chk("mid_valid", 32'(valid_o), 32'd0);
      chk("mid_idle", 32'(busy_o), 32'd0);
      idle(12 * 64);
      chk("mid_count_later", 32'(fifo_count_o), 32'd0);
      send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64);
      sb.push_back(11'h05A);
      pop_check("post_reset_entry");

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ssc_uart_rx.md
Name: ssc_uart_rx

Overview:
Serial receiver for the SuperSerial card; the receive side of the link whose transmit side drives uart_tx. Oversamples the asynchronous uart_rx pin at 16x a programmable baud rate and deframes 5–8 data bits, optional parity and 1 or 2 stop bits. Queues each received byte with its error flags in a small first-word-fall-through FIFO. The ACIA register logic pops that FIFO.

Parameters:
FIFO_DEPTH, 4, entries in receive FIFO (power of 2, ≥2)
SYNC_STAGES, 2, flip-flops in rx input synchronizer

Ports:
clk_logic  in  1  system logic clock (54 MHz)
reset  in  1  synchronous, active-high reset
rx_i  in  1  asynchronous serial input, idle high
baud_div_i  in  16  clk_logic cycles per oversample tick, minus 1
data_bits_i  in  2  data length: 0=5, 1=6, 2=7, 3=8
parity_en_i  in  1  parity bit present
parity_odd_i  in  1  1=odd, 0=even parity
stop2_i  in  1  two stop bits expected
data_o  out  8  head-of-FIFO byte; unused upper bits are 0
parity_err_o  out  1  head entry parity error
framing_err_o  out  1  head entry framing error
break_o  out  1  head entry is a break
valid_o  out  1  FIFO not empty
ready_i  in  1  pop; takes effect when valid_o is 1
overrun_o  out  1  sticky: byte dropped because FIFO was full
clear_err_i  in  1  clears overrun_o
fifo_count_o  out  $clog2(FIFO_DEPTH)+1  occupancy
busy_o  out  1  receiver not in IDLE

Behaviour:
- Reset values: all outputs 0. State IDLE, FIFO empty, tick counter loaded, armed=0.
- Synchronizer: rx_i passes through SYNC_STAGES flops, giving 2-cycle latency to rxs.
- Arming: the receiver is armed once rxs has been seen high. A line held low through reset never starts a frame.
- Tick generator: a down-counter reloads from baud_div_i and pulses tick when it reaches 0. It runs continuously. A new baud_div_i value takes effect at the next reload.
- Majority sampling: each bit is sampled on oversample ticks 7, 8 and 9 of the bit. The 2-of-3 majority, taken at tick 9, is the bit value.
- State machine; all transitions occur on tick unless noted:
  - IDLE: when armed and rxs=0 → START, phase counter = 0. Start detection is checked every clk_logic cycle.
  - START: at tick 9, majority=1 → IDLE (false start). Otherwise → DATA with bit index 0.
  - DATA: after 16 ticks per bit, shift the majority value in LSB-first. After data_bits_i+5 bits → PARITY if parity_en_i, else → STOP1.
  - PARITY: the expected parity is the XOR of the data bits, XOR parity_odd_i. A mismatch sets perr.
  - STOP1: majority=0 sets ferr. If all data bits, the parity bit and the stop bit are 0, set brk.
  - STOP1 with no brk: if stop2_i → STOP2; else push at tick 9 and → IDLE.
  - STOP1 with brk: push at tick 9 and → BRKWAIT.
  - STOP2: majority=0 sets ferr. Push at tick 9, → IDLE.
  - BRKWAIT: stay until rxs=1, checked every cycle, then → IDLE.
- Returning to IDLE at the mid-stop tick, not at bit end, is required so back-to-back frames resync on the next start edge.
- FIFO entry: {brk, ferr, perr, data[7:0]}, 11 bits.
  - valid_o rises the cycle after the push.
  - Pop when valid_o & ready_i.
- FIFO full:
  - Push on a full FIFO with no pop in the same cycle: the new entry is dropped and overrun_o is set.
  - Push and pop in the same cycle when full: both occur, no overrun.
  - Push and pop in the same cycle when empty: only the push occurs, since valid_o was 0.
- clear_err_i and a new overrun in the same cycle: overrun_o = 1 (set wins).
- Reset mid-frame: the frame is abandoned and the FIFO is flushed. Nothing is pushed.
- busy_o = (state != IDLE).

Decomposition:
- Package ssc_uart_pkg holds:
  - state enum rx_state_e: IDLE, START, DATA, PARITY, STOP1, STOP2, BRKWAIT.
  - struct rx_entry_t: brk, ferr, perr, data.
  - OVERSAMPLE = 16 and sample-tick constants 7, 8, 9.
- Sub-module ssc_uart_fifo: parameterised FWFT synchronous FIFO of rx_entry_t with count output. Reused later by the transmit path.

Test Plan:
- Standard frame: baud_div_i=3 (64 clk/bit), 8N1, send 0xA5 → one entry 0xA5, all error flags 0; valid_o rises 1 cycle after the mid-stop tick.
- 7 bits, odd parity, 2 stop bits, send 0x41 with bad parity → data_o=0x41, parity_err_o=1. Then 0x41 with correct parity → flag 0.
- Stop bit low after 0x55 → framing_err_o=1. A 12-bit-time low pulse → single entry with break_o=1, data 0x00, no further entries until the line returns high.
- Overrun and clear: FIFO_DEPTH=4 with ready_i=0, send 5 bytes 0x01..0x05 → entries 0x01..0x04 kept, overrun_o=1. Pop all → 0x01..0x04 in order. clear_err_i → overrun_o=0.
- Boundaries:
  - 1-bit-time/4 low glitch → no entry (false start).
  - rx held low through reset release → no entry until a high then a valid frame.
  - Push and pop in the same cycle when full → count stays 4, no overrun.
- Baud tolerance: transmitter at ±3% of nominal bit time, 0x00 and 0xFF → received correctly. Reset asserted mid-frame → FIFO empty, state IDLE.
